// File: rtl/crc_serial_engine_if.sv
// ---------------------------------------------------------------------------
// crc_serial_engine_if
// Request/result bundle for the bit-serial CRC engine.
//   START    request a run (sampled only while the engine is idle)
//   MODE     0 = generate, 1 = check (latched with START)
//   DATA_IN  message word (latched with START)
//   CRC_IN   received CRC for check mode (latched with START)
//   BUSY     run in progress
//   DONE     one-cycle pulse, result valid
//   CRC_OUT  final remainder, held until the next DONE
//   CRC_OK   check-mode pass flag, held until the next DONE
// master: requester side (front-end / bench); slave: the engine.
// ---------------------------------------------------------------------------
interface crc_serial_engine_if #(
    parameter int DATA_W = 16,
    parameter int CRC_W  = 16
);
    logic              START;
    logic              MODE;
    logic [DATA_W-1:0] DATA_IN;
    logic [CRC_W-1:0]  CRC_IN;
    logic              BUSY;
    logic              DONE;
    logic [CRC_W-1:0]  CRC_OUT;
    logic              CRC_OK;

    modport master (
        output START, MODE, DATA_IN, CRC_IN,
        input  BUSY, DONE, CRC_OUT, CRC_OK
    );

    modport slave (
        input  START, MODE, DATA_IN, CRC_IN,
        output BUSY, DONE, CRC_OUT, CRC_OK
    );
endinterface

// File: rtl/crc_serial_engine.sv
// ---------------------------------------------------------------------------
// crc_serial_engine
// Bit-serial CRC generator/checker. One run shifts DATA_W message bits
// followed by CRC_W tail bits (zeros when generating, the received CRC when
// checking) through an MSB-first, non-reflected LFSR divider. No final XOR.
// Ports:
//   CLK    clock, rising edge
//   RESET  synchronous, active-low; aborts any run without a DONE
//   bus    crc_serial_engine_if.slave (START/MODE/DATA_IN/CRC_IN in,
//          BUSY/DONE/CRC_OUT/CRC_OK out)
// Latency: START sampled at edge E0 -> DONE high after edge E0+N+1,
// N = DATA_W + CRC_W. START is ignored while BUSY.
// ---------------------------------------------------------------------------
module crc_serial_engine #(
    parameter int               DATA_W = 16,
    parameter int               CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY   = 16'h1021,
    parameter logic [CRC_W-1:0] INIT   = 16'h0000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    crc_serial_engine_if.slave   bus
);

    localparam int N     = DATA_W + CRC_W;
    localparam int CNT_W = $clog2(N + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     msg;      // latched message + tail, consumed MSB first
    logic [CRC_W-1:0] r;
    logic             mode_l;
    logic             busy;
    logic             done;
    logic [CRC_W-1:0] crc_out;
    logic             crc_ok;

    // One division step: shift in b, subtract (XOR) the polynomial when the
    // bit falling off the top is set.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] cur,
                                                  input logic             b);
        crc_step = {cur[CRC_W-2:0], b} ^ (cur[CRC_W-1] ? POLY : {CRC_W{1'b0}});
    endfunction

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            msg     <= '0;
            r       <= '0;
            mode_l  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            crc_out <= '0;
            crc_ok  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        // Tail is the received CRC in check mode, zeros
                        // (augmentation) in generate mode.
                        msg    <= {bus.DATA_IN,
                                   (bus.MODE ? bus.CRC_IN : {CRC_W{1'b0}})};
                        mode_l <= bus.MODE;
                        r      <= INIT;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    r   <= crc_step(r, msg[N-1]);
                    msg <= {msg[N-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(N - 1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    crc_out <= r;
                    crc_ok  <= mode_l & (r == {CRC_W{1'b0}});
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.BUSY    = busy;
    assign bus.DONE    = done;
    assign bus.CRC_OUT = crc_out;
    assign bus.CRC_OK  = crc_ok;

endmodule

// File: tb/tb_crc_serial_engine.sv
// ---------------------------------------------------------------------------
// tb_crc_serial_engine
// Directed bench for crc_serial_engine. A run-level model (polynomial long
// division on whole integers plus a start-to-done cycle count) predicts
// BUSY/DONE/CRC_OUT/CRC_OK of the default 16-bit instance every cycle;
// directed tests add literal expectations. A second 8-bit instance
// (POLY=0x07) is checked with literal expectations.
// ---------------------------------------------------------------------------
module tb_crc_serial_engine;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    crc_serial_engine_if #(.DATA_W(16), .CRC_W(16)) b16 ();
    crc_serial_engine_if #(.DATA_W(8),  .CRC_W(8))  b8  ();

    crc_serial_engine #(.DATA_W(16), .CRC_W(16), .POLY(16'h1021), .INIT(16'h0000)) dut16 (
        .CLK   (clk),
        .RESET (rst),
        .bus   (b16.slave)
    );

    crc_serial_engine #(.DATA_W(8), .CRC_W(8), .POLY(8'h07), .INIT(8'h00)) dut8 (
        .CLK   (clk),
        .RESET (rst),
        .bus   (b8.slave)
    );

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Remainder of (data * x^cw + tail) modulo (x^cw + poly), INIT = 0.
    function automatic logic [63:0] ref_rem(input logic [63:0] data, input logic [63:0] tail,
                                            input int dw, input int cw, input logic [63:0] poly);
        logic [63:0] m;
        logic [63:0] g;
        m = (data << cw) | tail;
        g = (64'd1 << cw) | poly;
        for (int i = dw + cw - 1; i >= cw; i--) begin
            if (m[i]) m = m ^ (g << (i - cw));
        end
        return m & ((64'd1 << cw) - 64'd1);
    endfunction

    // ---------------- run-level model of the 16-bit instance ----------------
    localparam int N16 = 32;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [15:0] m_out  = '0;
    logic        m_ok   = 1'b0;
    int          m_age  = 0;
    logic [15:0] m_data = '0;
    logic [15:0] m_crc  = '0;
    logic        m_mode = 1'b0;

    always @(posedge clk) begin
        logic [63:0] rem;
        if (!rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_out = '0; m_ok = 1'b0; m_age = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_age++;
                if (m_age == N16 + 1) begin
                    rem    = ref_rem({48'd0, m_data}, m_mode ? {48'd0, m_crc} : 64'd0,
                                     16, 16, 64'h1021);
                    m_out  = rem[15:0];
                    m_ok   = m_mode && (rem == 64'd0);
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (b16.START) begin
                m_data = b16.DATA_IN;
                m_crc  = b16.CRC_IN;
                m_mode = b16.MODE;
                m_busy = 1'b1;
                m_age  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_busy",    {63'd0, b16.BUSY},    {63'd0, m_busy});
            check("cyc_done",    {63'd0, b16.DONE},    {63'd0, m_done});
            check("cyc_crc_out", {48'd0, b16.CRC_OUT}, {48'd0, m_out});
            check("cyc_crc_ok",  {63'd0, b16.CRC_OK},  {63'd0, m_ok});
        end
    end

    // Issue one run on the 16-bit instance; lat = edges from START sample to
    // DONE high, or -1 if DONE never arrives.
    task automatic run16(input logic md, input logic [15:0] d, input logic [15:0] c,
                         output int lat);
        b16.MODE = md; b16.DATA_IN = d; b16.CRC_IN = c; b16.START = 1'b1;
        @(posedge clk); #1;
        b16.START = 1'b0;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (b16.DONE) begin lat = k; break; end
        end
    endtask

    task automatic run8(input logic md, input logic [7:0] d, input logic [7:0] c,
                        output int lat);
        b8.MODE = md; b8.DATA_IN = d; b8.CRC_IN = c; b8.START = 1'b1;
        @(posedge clk); #1;
        b8.START = 1'b0;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (b8.DONE) begin lat = k; break; end
        end
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int done_cnt;
        int first;
        int second;

        b16.START = 1'b0; b16.MODE = 1'b0; b16.DATA_IN = '0; b16.CRC_IN = '0;
        b8.START  = 1'b0; b8.MODE  = 1'b0; b8.DATA_IN  = '0; b8.CRC_IN  = '0;

        // Model pinned against hand-computed remainders.
        check("model_gen_0001", ref_rem(64'h0001, 64'd0, 16, 16, 64'h1021), 64'h1021);
        check("model_gen_0002", ref_rem(64'h0002, 64'd0, 16, 16, 64'h1021), 64'h2042);
        check("model_chk_1020", ref_rem(64'h0001, 64'h1020, 16, 16, 64'h1021), 64'h0001);
        check("model_crc8_01",  ref_rem(64'h01, 64'd0, 8, 8, 64'h07), 64'h07);

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",    {63'd0, b16.BUSY},    64'd0);
        check("reset_done",    {63'd0, b16.DONE},    64'd0);
        check("reset_crc_out", {48'd0, b16.CRC_OUT}, 64'd0);
        check("reset_crc_ok",  {63'd0, b16.CRC_OK},  64'd0);
        rst = 1'b1;
        cmp_en = 1'b1;
        @(posedge clk); #1;

        // Generate mode
        run16(1'b0, 16'h0001, 16'h0000, lat);
        check("gen1_latency", 64'(lat), 64'd33);
        check("gen1_crc_out", {48'd0, b16.CRC_OUT}, 64'h1021);
        check("gen1_crc_ok",  {63'd0, b16.CRC_OK},  64'd0);
        run16(1'b0, 16'h0002, 16'h0000, lat);
        check("gen2_crc_out", {48'd0, b16.CRC_OUT}, 64'h2042);
        run16(1'b0, 16'h0000, 16'h0000, lat);
        check("gen0_crc_out", {48'd0, b16.CRC_OUT}, 64'h0000);

        // Check mode
        run16(1'b1, 16'h0001, 16'h1021, lat);
        check("chk_good_ok",  {63'd0, b16.CRC_OK},  64'd1);
        check("chk_good_out", {48'd0, b16.CRC_OUT}, 64'h0000);
        run16(1'b1, 16'h0001, 16'h1020, lat);
        check("chk_bad_ok",   {63'd0, b16.CRC_OK},  64'd0);
        check("chk_bad_out",  {48'd0, b16.CRC_OUT}, 64'h0001);

        // START during a run is ignored
        b16.MODE = 1'b0; b16.DATA_IN = 16'h0001; b16.START = 1'b1;
        @(posedge clk); #1;
        b16.START = 1'b0;
        busy_cnt = b16.BUSY ? 1 : 0;
        done_cnt = 0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 5 || k == 20) begin
                b16.START = 1'b1; b16.DATA_IN = 16'hBEEF; b16.MODE = 1'b1;
            end else begin
                b16.START = 1'b0;
            end
            @(posedge clk); #1;
            busy_cnt += b16.BUSY ? 1 : 0;
            done_cnt += b16.DONE ? 1 : 0;
        end
        b16.START = 1'b0; b16.MODE = 1'b0;
        check("ign_done_count", 64'(done_cnt), 64'd1);
        check("ign_busy_cycles", 64'(busy_cnt), 64'd33);
        check("ign_crc_out", {48'd0, b16.CRC_OUT}, 64'h1021);

        // Back-to-back with START held high
        b16.DATA_IN = 16'h0001; b16.START = 1'b1;
        @(posedge clk); #1;
        b16.DATA_IN = 16'h0002;
        first = -1; second = -1;
        for (int k = 1; k <= 90; k++) begin
            @(posedge clk); #1;
            if (b16.DONE) begin
                if (first < 0) begin
                    first = k;
                    check("b2b_first_out", {48'd0, b16.CRC_OUT}, 64'h1021);
                end else begin
                    second = k;
                    check("b2b_second_out", {48'd0, b16.CRC_OUT}, 64'h2042);
                    b16.START = 1'b0;
                    break;
                end
            end
        end
        b16.START = 1'b0;
        check("b2b_first_lat", 64'(first), 64'd33);
        check("b2b_gap", 64'(second - first), 64'd34);
        repeat (40) @(posedge clk);
        #1;

        // Reset at shift 10 aborts the run
        b16.DATA_IN = 16'h0001; b16.START = 1'b1;
        @(posedge clk); #1;
        b16.START = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("rst_busy",    {63'd0, b16.BUSY},    64'd0);
        check("rst_crc_out", {48'd0, b16.CRC_OUT}, 64'd0);
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            done_cnt += b16.DONE ? 1 : 0;
        end
        check("rst_no_done", 64'(done_cnt), 64'd0);
        run16(1'b0, 16'h0002, 16'h0000, lat);
        check("rst_after_lat", 64'(lat), 64'd33);
        check("rst_after_out", {48'd0, b16.CRC_OUT}, 64'h2042);

        // 8-bit instance, POLY=0x07
        run8(1'b0, 8'h01, 8'h00, lat);
        check("c8_gen_latency", 64'(lat), 64'd17);
        check("c8_gen_out", {56'd0, b8.CRC_OUT}, 64'h07);
        check("c8_gen_ok",  {63'd0, b8.CRC_OK},  64'd0);
        run8(1'b1, 8'h01, 8'h07, lat);
        check("c8_chk_ok",  {63'd0, b8.CRC_OK},  64'd1);
        check("c8_chk_out", {56'd0, b8.CRC_OUT}, 64'h00);

        @(posedge clk); #1;
        cmp_en = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/crc_serial_engine.md
Name: crc_serial_engine

Overview:
Parametrised bit-serial CRC engine: generates or checks a CRC over a DATA_W-bit word in one run. Polynomial, width and init value are parameters, and a START/BUSY/DONE handshake sequences each run. It succeeds the fixed 16-bit switch-to-LED CRC datapath. It also adds a check mode that validates a received CRC. It sits between the switch/UART front-end and the display/status logic.

Parameters:
DATA_W, 16, message length in bits (>=1)
CRC_W, 16, CRC register width in bits (>=2)
POLY, 16'h1021, generator polynomial without implicit x^CRC_W term; bit 0 must be 1
INIT, 16'h0000, CRC register preset at start of each run (CRC_W bits)

Ports:
CLK  input  1  clock, all logic on rising edge
RESET  input  1  synchronous, active-low reset
START  input  1  request a run; sampled only in IDLE
MODE  input  1  0 = generate, 1 = check; latched with START
DATA_IN  input  DATA_W  message word, latched with START
CRC_IN  input  CRC_W  received CRC (check mode), latched with START
BUSY  output  1  run in progress
DONE  output  1  one-cycle pulse: result valid
CRC_OUT  output  CRC_W  final remainder, held until next DONE
CRC_OK  output  1  check-mode pass flag, held until next DONE

Behaviour:
- Reset: RESET is synchronous, active-low; clock CLK. While RESET=0 at an edge: state=IDLE, counter=0, BUSY=0, DONE=0, CRC_OUT=0, CRC_OK=0, internal shift/CRC regs=0. Reset mid-run aborts the run with no DONE.
- Algorithm: augmented-message long division, MSB first, non-reflected, no final XOR. Per shift with input bit b: fb=r[CRC_W-1]; r <= {r[CRC_W-2:0], b} ^ (fb ? POLY : 0).
- FSM states are IDLE, SHIFT, FINISH.
- IDLE: if START=1 at edge E0, latch DATA_IN, CRC_IN and MODE, load r<=INIT, clear counter, go to SHIFT. BUSY=1 from E0.
- SHIFT: N = DATA_W + CRC_W shift edges, E0+1 .. E0+N.
  - Shifts 1..DATA_W feed DATA_IN bits MSB first.
  - The next CRC_W shifts feed 0 (generate) or CRC_IN bits MSB first (check).
  - At edge E0+N, go to FINISH.
- FINISH: at edge E0+N+1:
  - CRC_OUT<=r
  - CRC_OK<=MODE_latched & (r==0); always 0 in generate mode
  - DONE<=1, BUSY<=0, go to IDLE.
- DONE clears at edge E0+N+2 unless a new result is produced.
- Latency: START sample to DONE high = N+1 edges (33 for defaults).
- START while BUSY=1 is ignored: no queuing, and latched inputs are unchanged.
- Back-to-back: START high during the DONE cycle (state IDLE) is accepted. The next run begins with no gap.
- CRC_OUT/CRC_OK change only at a FINISH edge or reset. DATA_IN/CRC_IN/MODE changes during a run have no effect.
- Counter width: $clog2(DATA_W+CRC_W+1). No wrap occurs within a run.
- Check mode with the CRC produced by generate mode for the same DATA_IN and INIT=0 yields r==0, so CRC_OK=1.

Test Plan:
- Defaults, generate, DATA_IN=16'h0001 -> DONE at edge 33 after START, CRC_OUT=16'h1021, CRC_OK=0. DATA_IN=16'h0002 -> 16'h2042. DATA_IN=16'h0000 -> 16'h0000.
- Defaults, check, DATA_IN=16'h0001, CRC_IN=16'h1021 -> CRC_OK=1, CRC_OUT=0. CRC_IN=16'h1020 -> CRC_OK=0, CRC_OUT=16'h0001.
- Pulse START again at cycles 5 and 20 of a run with different DATA_IN -> ignored. Exactly one DONE with the first run's result. BUSY high for 33 cycles.
- Back-to-back: START held high continuously with DATA_IN 0x0001 then 0x0002 -> DONE pulses 34 cycles apart with CRC_OUT 0x1021 then 0x2042.
- RESET=0 for one edge at shift 10 -> BUSY=0, DONE never pulses, CRC_OUT=0. A following START completes normally.
- DATA_W=8, CRC_W=8, POLY=8'h07, INIT=0: DATA_IN=8'h01 -> CRC_OUT=8'h07 after 17 edges. Check with CRC_IN=8'h07 -> CRC_OK=1.
